// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and limits for the multi-channel clock divider.
//   div_t          - divisor / high-time field at the default width
//   CH_MAX         - largest supported channel count
//   cfg_ch_width() - width of the channel-select field (never below 1 bit)
package clk_div_pkg;

    localparam int DIV_WIDTH_DEF = 12;
    localparam int CH_MAX        = 16;

    typedef logic [DIV_WIDTH_DEF-1:0] div_t;

    function automatic int cfg_ch_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: configuration bus of the divider bank.
//   cfg_we  - write strobe
//   cfg_ch  - target channel; values >= CH are dropped by the divider
//   cfg_div - new divisor D (period = D+1 cycles)
//   cfg_hi  - new high time H in cycles
//   pend    - per-channel flag: a written configuration is waiting to apply
// master drives the writes, slave is the divider bank.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int CH        = 4,
    parameter int DIV_WIDTH = 12
);
    localparam int CH_W = cfg_ch_width(CH);

    logic                 cfg_we;
    logic [CH_W-1:0]      cfg_ch;
    logic [DIV_WIDTH-1:0] cfg_div;
    logic [DIV_WIDTH-1:0] cfg_hi;
    logic [CH-1:0]        pend;

    modport master (output cfg_we, cfg_ch, cfg_div, cfg_hi, input pend);
    modport slave  (input cfg_we, cfg_ch, cfg_div, cfg_hi, output pend);
endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel.
//   clk, rst       - clock, synchronous active-high reset
//   en             - run enable; low holds the counter at 0 and the outputs low
//   sync           - realign: counter back to 0 on the next edge
//   wr             - store wr_div / wr_hi as the pending configuration
//   clk_out, tick  - registered divided clock and period-start strobe
//   pend           - pending configuration not yet applied
module clk_div_chan #(
    parameter int DIV_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync,
    input  logic                 wr,
    input  logic [DIV_WIDTH-1:0] wr_div,
    input  logic [DIV_WIDTH-1:0] wr_hi,
    output logic                 clk_out,
    output logic                 tick,
    output logic                 pend
);
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] d_act;
    logic [DIV_WIDTH-1:0] h_act;
    logic [DIV_WIDTH-1:0] d_pend;
    logic [DIV_WIDTH-1:0] h_pend;
    logic                 at_end;
    logic                 restart;
    logic                 apply;

    // Every event that returns the counter to 0 is also a safe point to swap
    // in the pending configuration, so the running period is never cut short.
    assign at_end  = (cnt == d_act);
    assign restart = !en || sync || at_end;
    assign apply   = pend && restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            d_act   <= '0;
            h_act   <= '0;
            d_pend  <= '0;
            h_pend  <= '0;
            pend    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt <= restart ? '0 : cnt + DIV_WIDTH'(1);

            if (apply) begin
                d_act <= d_pend;
                h_act <= h_pend;
            end

            // A write landing on the apply cycle keeps pend set: the old pending
            // values go active while the new ones wait for the next boundary.
            if (wr) begin
                d_pend <= wr_div;
                h_pend <= wr_hi;
                pend   <= 1'b1;
            end else if (apply) begin
                pend   <= 1'b0;
            end

            clk_out <= en && (cnt < h_act);
            tick    <= en && (cnt == '0);
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: bank of CH independent programmable clock dividers.
//   clk, rst  - clock, synchronous active-high reset
//   en[CH]    - per-channel run enable
//   sync      - one-cycle pulse realigning all enabled channels
//   cfg       - configuration bus (write strobe, channel, D, H, pend flags)
//   clk_out   - divided clocks, high while cnt < H
//   tick      - one-cycle strobe at each period start
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CH        = 4,
    parameter int DIV_WIDTH = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] en,
    input  logic          sync,
    clk_div_multi_if.slave cfg,
    output logic [CH-1:0] clk_out,
    output logic [CH-1:0] tick
);
    localparam int CH_W = cfg_ch_width(CH);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        logic wr;

        // Channel numbers >= CH match no instance, so such writes vanish.
        assign wr = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

        clk_div_chan #(
            .DIV_WIDTH (DIV_WIDTH)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync),
            .wr      (wr),
            .wr_div  (cfg.cfg_div),
            .wr_hi   (cfg.cfg_hi),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (cfg.pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed bench for clk_div_multi with three channels, so
// that channel index 3 is representable and must be rejected.
module tb_clk_div_multi;
    localparam int CH = 3;
    localparam int DW = 12;

    logic          clk;
    logic          rst;
    logic [CH-1:0] en;
    logic          sync;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_t;
    logic exp_c;

    clk_div_multi_if #(.CH(CH), .DIV_WIDTH(DW)) cfg_if ();

    clk_div_multi #(.CH(CH), .DIV_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .cfg     (cfg_if.slave),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_wr(input logic [1:0] ch, input int d, input int h);
        cfg_if.cfg_we  = 1'b1;
        cfg_if.cfg_ch  = ch;
        cfg_if.cfg_div = DW'(d);
        cfg_if.cfg_hi  = DW'(h);
    endtask

    task automatic cfg_write(input logic [1:0] ch, input int d, input int h);
        set_wr(ch, d, h);
        cyc(1);
        cfg_if.cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = '0; sync = 1'b0;
        cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0;
        cfg_if.cfg_div = '0; cfg_if.cfg_hi = '0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '1; sync = 1'b1;
        set_wr(2'd0, 5, 3);
        cyc(2);
        n_checks++;
        if ({clk_out, tick, cfg_if.pend} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got clk_out=%b tick=%b pend=%b, want all 0", clk_out, tick, cfg_if.pend);
        end
        rst = 1'b0; sync = 1'b0; cfg_if.cfg_we = 1'b0; en = 3'b001;
        // D_act=0, H_act=0 after reset: tick every cycle, clk_out low
        for (int n = 1; n <= 3; n++) begin
            cyc(1);
            n_checks++;
            if (tick[0] !== 1'b1 || clk_out[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_defaults n=%0d: got tick=%b clk_out=%b, want tick=1 clk_out=0", n, tick[0], clk_out[0]);
            end
        end
    endtask

    task automatic test_basic_and_disable();
        do_reset();
        cfg_write(2'd0, 9, 5);
        n_checks++;
        if (cfg_if.pend !== 3'b001) begin
            n_fail++;
            $display("FAIL basic_pend_set: got %b, want 001", cfg_if.pend);
        end
        cyc(1);
        n_checks++;
        if (cfg_if.pend !== 3'b000) begin
            n_fail++;
            $display("FAIL basic_pend_apply_disabled: got %b, want 000", cfg_if.pend);
        end
        en = 3'b001;
        for (int n = 1; n <= 33; n++) begin
            cyc(1);
            exp_t = ((n - 1) % 10 == 0);
            exp_c = ((n - 1) % 10 < 5);
            n_checks++;
            if (tick[0] !== exp_t || clk_out[0] !== exp_c) begin
                n_fail++;
                $display("FAIL basic n=%0d: got tick=%b clk_out=%b, want tick=%b clk_out=%b", n, tick[0], clk_out[0], exp_t, exp_c);
            end
        end
        en = 3'b000;
        for (int n = 1; n <= 3; n++) begin
            cyc(1);
            n_checks++;
            if (tick[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL disable n=%0d: got tick=%b clk_out=%b, want 0 0", n, tick[0], clk_out[0]);
            end
        end
        en = 3'b001;
        for (int n = 1; n <= 12; n++) begin
            cyc(1);
            exp_t = ((n - 1) % 10 == 0);
            exp_c = ((n - 1) % 10 < 5);
            n_checks++;
            if (tick[0] !== exp_t || clk_out[0] !== exp_c) begin
                n_fail++;
                $display("FAIL reenable n=%0d: got tick=%b clk_out=%b, want tick=%b clk_out=%b", n, tick[0], clk_out[0], exp_t, exp_c);
            end
        end
    endtask

    // Two writes mid-period (last one wins); switch at the D=9 boundary.
    task automatic test_reconfig();
        do_reset();
        cfg_write(2'd0, 9, 5);
        cyc(1);
        en = 3'b001;
        for (int n = 1; n <= 26; n++) begin
            cyc(1);
            if (n <= 10) begin
                exp_t = ((n - 1) % 10 == 0);
                exp_c = ((n - 1) % 10 < 5);
            end else begin
                exp_t = ((n - 11) % 4 == 0);
                exp_c = ((n - 11) % 4 < 2);
            end
            n_checks++;
            if (tick[0] !== exp_t || clk_out[0] !== exp_c) begin
                n_fail++;
                $display("FAIL reconfig n=%0d: got tick=%b clk_out=%b, want tick=%b clk_out=%b", n, tick[0], clk_out[0], exp_t, exp_c);
            end
            if (n == 2) set_wr(2'd0, 1, 1);
            if (n == 3) cfg_if.cfg_we = 1'b0;
            if (n == 4) set_wr(2'd0, 3, 2);
            if (n == 5) begin
                cfg_if.cfg_we = 1'b0;
                n_checks++;
                if (cfg_if.pend[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reconfig_pend_wait: got %b, want 1", cfg_if.pend[0]);
                end
            end
            if (n == 10) begin
                n_checks++;
                if (cfg_if.pend[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reconfig_pend_clear: got %b, want 0", cfg_if.pend[0]);
                end
            end
        end
    endtask

    // Write lands on the boundary cycle: old pending (D=3) applies, D=7 waits.
    task automatic test_apply_collision();
        do_reset();
        cfg_write(2'd0, 9, 5);
        cyc(1);
        en = 3'b001;
        for (int n = 1; n <= 31; n++) begin
            cyc(1);
            if (n <= 10) begin
                exp_t = ((n - 1) % 10 == 0);
                exp_c = ((n - 1) % 10 < 5);
            end else if (n <= 14) begin
                exp_t = (n == 11);
                exp_c = (n - 11 < 2);
            end else begin
                exp_t = ((n - 15) % 8 == 0);
                exp_c = ((n - 15) % 8 < 4);
            end
            n_checks++;
            if (tick[0] !== exp_t || clk_out[0] !== exp_c) begin
                n_fail++;
                $display("FAIL collision n=%0d: got tick=%b clk_out=%b, want tick=%b clk_out=%b", n, tick[0], clk_out[0], exp_t, exp_c);
            end
            if (n == 2) set_wr(2'd0, 3, 2);
            if (n == 3) cfg_if.cfg_we = 1'b0;
            if (n == 9) set_wr(2'd0, 7, 4);
            if (n == 10) begin
                cfg_if.cfg_we = 1'b0;
                n_checks++;
                if (cfg_if.pend[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL collision_pend_kept: got %b, want 1", cfg_if.pend[0]);
                end
            end
            if (n == 14) begin
                n_checks++;
                if (cfg_if.pend[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL collision_pend_clear: got %b, want 0", cfg_if.pend[0]);
                end
            end
        end
    endtask

    // sync sampled at edge 5 realigns ch0 (D=5) and ch1 (D=2) and applies ch0's
    // pending H=1; ch2 stays disabled.
    task automatic test_sync();
        logic exp_t1;
        do_reset();
        cfg_write(2'd0, 5, 3);
        cfg_write(2'd1, 2, 1);
        cfg_write(2'd2, 1, 1);
        cyc(1);
        en = 3'b011;
        for (int n = 1; n <= 13; n++) begin
            cyc(1);
            if (n <= 5) begin
                exp_t  = (n == 1);
                exp_c  = ((n - 1) % 6 < 3);
                exp_t1 = ((n - 1) % 3 == 0);
            end else begin
                exp_t  = ((n - 6) % 6 == 0);
                exp_c  = ((n - 6) % 6 == 0);
                exp_t1 = ((n - 6) % 3 == 0);
            end
            n_checks++;
            if (tick[0] !== exp_t || clk_out[0] !== exp_c || tick[1] !== exp_t1) begin
                n_fail++;
                $display("FAIL sync n=%0d: got tick0=%b clk_out0=%b tick1=%b, want %b %b %b", n, tick[0], clk_out[0], tick[1], exp_t, exp_c, exp_t1);
            end
            n_checks++;
            if ({tick[2], clk_out[2]} !== 2'b00) begin
                n_fail++;
                $display("FAIL sync_disabled_ch2 n=%0d: got tick=%b clk_out=%b, want 0 0", n, tick[2], clk_out[2]);
            end
            if (n == 2) set_wr(2'd0, 5, 1);
            if (n == 3) cfg_if.cfg_we = 1'b0;
            if (n == 4) sync = 1'b1;
            if (n == 5) begin
                sync = 1'b0;
                n_checks++;
                if (cfg_if.pend[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sync_apply_pend: got %b, want 0", cfg_if.pend[0]);
                end
            end
        end
    endtask

    task automatic test_boundaries();
        do_reset();
        cfg_write(2'd0, 3, 0);
        cyc(1);
        en = 3'b001;
        for (int n = 1; n <= 8; n++) begin
            cyc(1);
            exp_t = ((n - 1) % 4 == 0);
            n_checks++;
            if (clk_out[0] !== 1'b0 || tick[0] !== exp_t) begin
                n_fail++;
                $display("FAIL h_zero n=%0d: got clk_out=%b tick=%b, want 0 %b", n, clk_out[0], tick[0], exp_t);
            end
        end
        do_reset();
        cfg_write(2'd0, 9, 20);
        cyc(1);
        en = 3'b001;
        for (int n = 1; n <= 20; n++) begin
            cyc(1);
            n_checks++;
            if (clk_out[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL h_over_d n=%0d: got clk_out=%b, want 1", n, clk_out[0]);
            end
        end
        do_reset();
        cfg_write(2'd0, 0, 1);
        cyc(1);
        en = 3'b001;
        for (int n = 1; n <= 6; n++) begin
            cyc(1);
            n_checks++;
            if (tick[0] !== 1'b1 || clk_out[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL d_zero n=%0d: got tick=%b clk_out=%b, want 1 1", n, tick[0], clk_out[0]);
            end
        end
        cfg_write(2'd3, 9, 0);
        n_checks++;
        if (cfg_if.pend !== 3'b000) begin
            n_fail++;
            $display("FAIL bad_channel_pend: got %b, want 000", cfg_if.pend);
        end
        for (int n = 1; n <= 4; n++) begin
            cyc(1);
            n_checks++;
            if (tick[0] !== 1'b1 || clk_out[0] !== 1'b1 || cfg_if.pend !== 3'b000) begin
                n_fail++;
                $display("FAIL bad_channel_nochange n=%0d: got tick=%b clk_out=%b pend=%b, want 1 1 000", n, tick[0], clk_out[0], cfg_if.pend);
            end
        end
    endtask

    task automatic test_reset_midperiod();
        do_reset();
        cfg_write(2'd0, 9, 5);
        cyc(1);
        en = 3'b001;
        for (int n = 1; n <= 4; n++) begin
            cyc(1);
            if (n == 2) set_wr(2'd0, 3, 2);
            if (n == 3) cfg_if.cfg_we = 1'b0;
        end
        rst = 1'b1; sync = 1'b1;
        set_wr(2'd0, 7, 7);
        cyc(1);
        n_checks++;
        if (clk_out !== '0 || tick !== '0 || cfg_if.pend !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got clk_out=%b tick=%b pend=%b, want 000 000 000", clk_out, tick, cfg_if.pend);
        end
        rst = 1'b0; sync = 1'b0; cfg_if.cfg_we = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            cyc(1);
            n_checks++;
            if (tick[0] !== 1'b1 || clk_out[0] !== 1'b0 || cfg_if.pend[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_dact n=%0d: got tick=%b clk_out=%b pend=%b, want 1 0 0", n, tick[0], clk_out[0], cfg_if.pend[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = '0; sync = 1'b0;
        cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0;
        cfg_if.cfg_div = '0; cfg_if.cfg_hi = '0;
        test_reset();
        test_basic_and_disable();
        test_reconfig();
        test_apply_collision();
        test_sync();
        test_boundaries();
        test_reset_midperiod();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent divider channels, 1..16.
REQ-002 SHALL have parameter DIV_WIDTH, default 12: width of divisor and high-time fields.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, CH: per-channel run enable.
REQ-006 SHALL have port sync, input, 1: one-cycle pulse that phase-aligns all enabled channels.
REQ-007 SHALL have port cfg_we, input, 1: configuration write strobe.
REQ-008 SHALL have port cfg_ch, input, $clog2(CH) (min 1): target channel of the write.
REQ-009 SHALL have port cfg_div, input, DIV_WIDTH: new divisor D, where period = D+1 clk cycles.
REQ-010 SHALL have port cfg_hi, input, DIV_WIDTH: new high time H, in clk cycles.
REQ-011 SHALL have port clk_out, output, CH: registered divided clocks.
REQ-012 SHALL have port tick, output, CH: registered one-cycle strobe at each period start.
REQ-013 SHALL have port pend, output, CH: a written configuration is waiting to be applied.

Function
REQ-014 Per channel SHALL keep a counter cnt that runs 0..D_act and wraps to 0 while en=1; D_act=0 gives period 1.
REQ-015 clk_out[i] SHALL be registered (cnt < H_act), one cycle after cnt; H=0 gives constant low, H>D gives constant high.
REQ-016 tick[i] SHALL be registered (cnt==0 && en[i]), so it is high for one cycle per period.
REQ-017 cfg_we SHALL load cfg_div/cfg_hi into pending registers of channel cfg_ch and set pend[cfg_ch] on the next edge; cfg_ch >= CH SHALL be ignored.
REQ-018 Pending values SHALL be copied to D_act/H_act, and pend cleared, at the period boundary (cnt==D_act), when en[i]=0, or on sync.
REQ-019 The new configuration SHALL take effect from the next cnt=0; the current period SHALL never be truncated or lengthened, giving glitch-free output.
REQ-020 If cfg_we hits a channel in the same cycle as its apply, the old pending values SHALL apply, the new values SHALL be stored, and pend SHALL stay 1.
REQ-021 A second write while pend=1 SHALL overwrite the pending values (last write wins).
REQ-022 While en[i]=0: cnt=0, clk_out[i]=0, tick[i]=0 from the next edge. Re-enable SHALL start at cnt=0, so the first tick comes one cycle later.
REQ-023 sync SHALL force cnt=0 in all enabled channels on the next edge and apply pending values. sync SHALL take precedence over wrap, and disabled channels SHALL not be affected.
REQ-024 Counter arithmetic SHALL be DIV_WIDTH unsigned, and the comparison with H SHALL be unsigned.

Reset
REQ-025 rst SHALL set cnt=0, D_act=0, H_act=0, pending=0, pend=0, clk_out=0 and tick=0.
REQ-026 rst SHALL override en, sync and cfg_we in the same cycle; reset mid-period SHALL abandon the period with no extra tick.

Structure
REQ-027 Package clk_div_pkg SHALL hold the typedef div_t (logic [DIV_WIDTH-1:0], default width) and the channel-count limit constant.
REQ-028 Sub-module clk_div_chan SHALL implement one channel (counter, active/pending registers, outputs), instantiated CH times by generate.

Verification
REQ-029 Write ch0 D=9, H=5, en[0]=1 -> tick[0] every 10 cycles, clk_out[0] high 5 / low 5.
REQ-030 Running D=9, write D=3, H=2 at cnt=4 -> pend=1, current 10-cycle period completes, then 4-cycle periods, no runt pulse.
REQ-031 Write D=7 exactly at cnt==D_act -> old pending applied, pend stays 1, D=7 applied at the following boundary.
REQ-032 ch0 D=5, ch1 D=2, assert sync mid-period -> both tick together 2 cycles later; ch2 with en=0 stays low.
REQ-033 Boundaries: H=0 -> clk_out constant 0; H=20 with D=9 -> constant 1; D=0 -> tick constant 1; cfg_ch=CH -> no change.
REQ-034 rst asserted mid-period with pend=1 -> all outputs 0 next cycle, pend cleared, D_act=0.
